// File: rtl/custom_axi_pkg.sv
// Shared constants, state encodings and helpers for the custom_axi_regs
// AXI4-Lite register block.
package custom_axi_pkg;

   localparam int unsigned REG_W  = 32;
   localparam int unsigned STRB_W = REG_W / 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned WORD_W = 30;

   localparam int unsigned DATA_BASE  = 32'h0;
   localparam int unsigned STATUS_OFF = 32'hC;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_e;

   typedef struct packed {
      logic             is_data;
      logic             is_status;
      logic [IDX_W-1:0] idx;
   } addr_dec_t;

   // STATUS is checked first so it owns 0xC even when NUM_REGS > 3.
   function automatic addr_dec_t decode_addr(input logic [WORD_W-1:0] word,
                                             input int unsigned num_regs);
      logic [31:0] data_word;
      decode_addr = '0;
      data_word   = 32'(word) - (DATA_BASE >> 2);
      if (32'(word) == (STATUS_OFF >> 2)) begin
         decode_addr.is_status = 1'b1;
      end else if (data_word < num_regs) begin
         decode_addr.is_data = 1'b1;
         decode_addr.idx     = IDX_W'(data_word);
      end
   endfunction

   function automatic logic [REG_W-1:0] strb_merge(input logic [REG_W-1:0]  old_val,
                                                   input logic [REG_W-1:0]  new_val,
                                                   input logic [STRB_W-1:0] strb);
      strb_merge = old_val;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (strb[b]) strb_merge[b*8 +: 8] = new_val[b*8 +: 8];
      end
   endfunction

endpackage

// File: rtl/custom_axi_regs.sv
// AXI4-Lite slave exposing NUM_REGS write registers toward the IP, shadow
// registers captured from the IP, and a read-only STATUS of pending shadows.
module custom_axi_regs
   import custom_axi_pkg::*;
#(
   parameter int unsigned NUM_REGS = 3,
   parameter int unsigned ADDR_W   = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [ADDR_W-1:0]         awaddr,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [31:0]               wdata,
   input  logic [3:0]                wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   input  logic [ADDR_W-1:0]         araddr,
   input  logic                      arvalid,
   output logic                      arready,
   output logic [31:0]               rdata,
   output logic [1:0]                rresp,
   output logic                      rvalid,
   input  logic                      rready,
   output logic [NUM_REGS*32-1:0]    reg2ip_data,
   output logic [NUM_REGS-1:0]       reg2ip_en,
   input  logic [NUM_REGS*32-1:0]    ip2reg_data,
   input  logic [NUM_REGS-1:0]       ip2reg_en
);

   localparam int unsigned AWORD_W = ADDR_W - 2;

   // Write channel state
   w_state_e                         w_state_q, w_state_d;
   logic [AWORD_W-1:0]               aw_word_q, aw_word_d;
   logic [REG_W-1:0]                 w_data_q, w_data_d;
   logic [STRB_W-1:0]                w_strb_q, w_strb_d;
   logic                             awready_q, awready_d;
   logic                             wready_q, wready_d;
   logic                             bvalid_q, bvalid_d;
   logic [1:0]                       bresp_q, bresp_d;
   logic [NUM_REGS-1:0][REG_W-1:0]   reg2ip_data_q, reg2ip_data_d;
   logic [NUM_REGS-1:0]              reg2ip_en_q, reg2ip_en_d;

   // Read channel state
   r_state_e                         r_state_q, r_state_d;
   logic                             arready_q, arready_d;
   logic                             rvalid_q, rvalid_d;
   logic [REG_W-1:0]                 rdata_q, rdata_d;
   logic [1:0]                       rresp_q, rresp_d;

   // IP capture state
   logic [NUM_REGS-1:0][REG_W-1:0]   shadow_q, shadow_d;
   logic [NUM_REGS-1:0]              valid_q, valid_d;

   logic                             aw_hs, w_hs, do_write, wr_ok, ar_hs;
   logic [AWORD_W-1:0]               eff_word;
   logic [REG_W-1:0]                 eff_data;
   logic [STRB_W-1:0]                eff_strb;
   addr_dec_t                        wdec, rdec;
   logic [NUM_REGS-1:0]              rd_clr_c;
   logic                             unused_addr_lsbs;

   assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

   assign awready     = awready_q;
   assign wready      = wready_q;
   assign bvalid      = bvalid_q;
   assign bresp       = bresp_q;
   assign reg2ip_data = reg2ip_data_q;
   assign reg2ip_en   = reg2ip_en_q;
   assign arready     = arready_q;
   assign rvalid      = rvalid_q;
   assign rdata       = rdata_q;
   assign rresp       = rresp_q;

   // Write FSM: the write commits on the edge that completes the AW/W pair,
   // using the live channel value for whichever half arrives last.
   always_comb begin
      w_state_d     = w_state_q;
      aw_word_d     = aw_word_q;
      w_data_d      = w_data_q;
      w_strb_d      = w_strb_q;
      bvalid_d      = bvalid_q;
      bresp_d       = bresp_q;
      reg2ip_data_d = reg2ip_data_q;
      reg2ip_en_d   = '0;
      do_write      = 1'b0;

      aw_hs    = awvalid && awready_q;
      w_hs     = wvalid && wready_q;
      eff_word = aw_hs ? awaddr[ADDR_W-1:2] : aw_word_q;
      eff_data = w_hs ? wdata : w_data_q;
      eff_strb = w_hs ? wstrb : w_strb_q;
      wdec     = decode_addr(WORD_W'(eff_word), NUM_REGS);
      wr_ok    = wdec.is_data && !wdec.is_status;

      if (aw_hs) aw_word_d = awaddr[ADDR_W-1:2];
      if (w_hs) begin
         w_data_d = wdata;
         w_strb_d = wstrb;
      end

      unique case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) do_write = 1'b1;
            else if (aw_hs)    w_state_d = W_HAVE_AW;
            else if (w_hs)     w_state_d = W_HAVE_W;
         end
         W_HAVE_AW: if (w_hs)  do_write = 1'b1;
         W_HAVE_W:  if (aw_hs) do_write = 1'b1;
         W_RESP: begin
            if (bready) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase

      if (do_write) begin
         w_state_d = W_RESP;
         bvalid_d  = 1'b1;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && 32'(wdec.idx) == i) begin
               reg2ip_data_d[i] = strb_merge(reg2ip_data_q[i], eff_data, eff_strb);
               reg2ip_en_d[i]   = 1'b1;
            end
         end
      end

      awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
      wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q     <= W_IDLE;
         aw_word_q     <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         awready_q     <= 1'b1;
         wready_q      <= 1'b1;
         bvalid_q      <= 1'b0;
         bresp_q       <= RESP_OKAY;
         reg2ip_data_q <= '0;
         reg2ip_en_q   <= '0;
      end else begin
         w_state_q     <= w_state_d;
         aw_word_q     <= aw_word_d;
         w_data_q      <= w_data_d;
         w_strb_q      <= w_strb_d;
         awready_q     <= awready_d;
         wready_q      <= wready_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         reg2ip_data_q <= reg2ip_data_d;
         reg2ip_en_q   <= reg2ip_en_d;
      end
   end

   // Read FSM: response data is sampled from the shadows as they stood
   // before this edge, so a same-cycle IP capture is not visible yet.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_clr_c  = '0;

      ar_hs = arvalid && arready_q;
      rdec  = decode_addr(WORD_W'(araddr[ADDR_W-1:2]), NUM_REGS);

      unique case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_RESP;
               rvalid_d  = 1'b1;
               rdata_d   = '0;
               rresp_d   = RESP_OKAY;
               if (rdec.is_status) begin
                  rdata_d = REG_W'(valid_q);
               end else if (rdec.is_data) begin
                  for (int unsigned i = 0; i < NUM_REGS; i++) begin
                     if (32'(rdec.idx) == i) begin
                        rdata_d     = shadow_q[i];
                        rd_clr_c[i] = 1'b1;
                     end
                  end
               end else begin
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         R_RESP: begin
            if (rready) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase

      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Shadow capture: an IP load in the same cycle as a read-clear leaves valid set.
   always_comb begin
      shadow_d = shadow_q;
      valid_d  = valid_q & ~rd_clr_c;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (ip2reg_en[i]) begin
            shadow_d[i] = ip2reg_data[i*REG_W +: REG_W];
            valid_d[i]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         valid_q  <= '0;
      end else begin
         shadow_q <= shadow_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: doc/custom_axi_regs.md
CUSTOM_AXI_REGS -- requirements
Module: custom_axi_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 3: number of IP data registers (1..7).
REQ-002 SHALL have parameter ADDR_W, default 4: AXI4-Lite address width (byte addressing).
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  AXI4-Lite write address channel.
- wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- reg2ip_data  out  NUM_REGS x 32  written register value toward IP.
- reg2ip_en  out  NUM_REGS  one-cycle write strobe per register.
- ip2reg_data  in  NUM_REGS x 32  IP-produced value.
- ip2reg_en  in  NUM_REGS  capture qualifier per register.

Function
REQ-004 Address map SHALL be: offset 4*i = DATA[i] for i < NUM_REGS; offset 0xC = STATUS (read-only); all other offsets decode as invalid.
REQ-005 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP; AW and W accepted independently in any order or in the same cycle.
REQ-006 awready SHALL be high only in W_IDLE and W_HAVE_W; wready only in W_IDLE and W_HAVE_AW.
REQ-007 On holding both address and data, the FSM SHALL perform the write and enter W_RESP with bvalid=1 in the next cycle, holding until bready; then W_IDLE.
REQ-008 Valid DATA[i] write SHALL apply wstrb byte-wise to the write register i, drive reg2ip_data[i] with the merged value, and pulse reg2ip_en[i] high for exactly one cycle, coincident with bvalid rising.
REQ-009 reg2ip_data[i] SHALL hold its last written value between strobes.
REQ-010 Write to STATUS or an invalid offset SHALL change no state, pulse no strobe, and return bresp=SLVERR (2'b10); valid writes return OKAY (2'b00).
REQ-011 Read FSM SHALL have states R_IDLE, R_RESP; arready=1 only in R_IDLE; accepted read SHALL assert rvalid next cycle with rdata/rresp registered and stable until rready.
REQ-012 Each cycle ip2reg_en[i]=1, shadow[i] SHALL load ip2reg_data[i] and STATUS bit i (valid[i]) SHALL set.
REQ-013 DATA[i] read SHALL return shadow[i] and clear valid[i]; STATUS read SHALL return {zeros, valid[NUM_REGS-1:0]} without side effects.
REQ-014 Invalid-offset read SHALL return rdata=0, rresp=SLVERR.
REQ-015 Simultaneous ip2reg_en[i] and DATA[i] read acceptance: rdata SHALL be the pre-update shadow; valid[i] SHALL end set (set wins).
REQ-016 Read and write channels SHALL operate concurrently; a same-cycle write to DATA[i] and read of DATA[i] SHALL not interact (read returns shadow, not write register).
REQ-017 Address bits [1:0] SHALL be ignored.

Reset
REQ-018 While rst_i=1 at a clock edge: both FSMs idle, awready=wready=arready=1 after reset release only per REQ-006/011, bvalid=rvalid=0, bresp=rresp=0, rdata=0, reg2ip_en=0, reg2ip_data=0, shadow=0, valid=0.
REQ-019 Reset mid-transaction SHALL abandon it with no strobe and no response.

Structure
REQ-020 Package custom_axi_pkg SHALL hold offset constants (DATA_BASE, STATUS_OFF), response codes (RESP_OKAY, RESP_SLVERR), and FSM state enums.
REQ-021 Single module; no sub-module; one always_ff per FSM plus one for shadow/valid.

Verification
REQ-022 AW then W two cycles later to 0x4, wdata=0xDEADBEEF, wstrb=0xF -> reg2ip_en=3'b010 one cycle, reg2ip_data[1]=0xDEADBEEF, bresp=OKAY.
REQ-023 W before AW to 0x0 holding 0x11223344, then wdata=0xAABBCCDD, wstrb=0x3 -> reg2ip_data[0]=0x1122CCDD.
REQ-024 ip2reg_en[2]=1, ip2reg_data[2]=0x5A5A0001 -> STATUS read=0x4; DATA[2] read=0x5A5A0001; STATUS read=0x0.
REQ-025 Write and read to 0x10 (NUM_REGS=3, ADDR_W=5) -> bresp=SLVERR, rresp=SLVERR, rdata=0, no reg2ip_en pulse.
REQ-026 ip2reg_en[0] in the DATA[0] read-accept cycle, shadow old 0x1, new 0x2 -> rdata=0x1, STATUS bit0=1.
REQ-027 bready held low 5 cycles then rst_i=1 -> bvalid=0 next edge, awready=1 after release, no strobe.
